// File: rtl/cache_ctrl.sv
// Write-back, write-allocate cache controller driving a single cache `set` block.
// One outstanding CPU request; a miss writes back a dirty victim, fills four words, then retries.
module cache_ctrl #(
  parameter int TAG_W   = 5,
  parameter int INDEX_W = 3,
  parameter int DATA_W  = 16,
  parameter int WORDS   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [TAG_W+INDEX_W+1:0] cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_ready,
  output logic                     cpu_busy,
  output logic [INDEX_W-1:0]       set_index,
  output logic                     set_enable,
  output logic [1:0]               set_word,
  output logic                     set_cmp,
  output logic                     set_write,
  output logic [TAG_W-1:0]         set_tag,
  output logic [DATA_W-1:0]        set_data_in,
  output logic                     set_valid_in,
  input  logic                     set_hit,
  input  logic                     set_dirty,
  input  logic                     set_valid,
  input  logic                     set_ack,
  input  logic [TAG_W-1:0]         set_tag_out,
  input  logic [DATA_W-1:0]        set_data_out,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [TAG_W+INDEX_W+1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ack
);

  localparam int         ADDR_W    = TAG_W + INDEX_W + 2;
  localparam logic [1:0] LAST_WORD = 2'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_WB_RD, S_WB_MEM, S_FILL_MEM, S_FILL_WR, S_DONE
  } state_t;

  logic [TAG_W-1:0]   w_req_tag;
  logic [INDEX_W-1:0] w_req_index;
  logic [1:0]         w_req_word;

  assign w_req_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
  assign w_req_index = cpu_addr[2 +: INDEX_W];
  assign w_req_word  = cpu_addr[1:0];

  state_t             r_state;
  logic [1:0]         r_cnt;
  logic               r_we;
  logic [TAG_W-1:0]   r_tag;
  logic [1:0]         r_word;
  logic [DATA_W-1:0]  r_wdata;
  logic [TAG_W-1:0]   r_victim_tag;
  logic [DATA_W-1:0]  r_data;
  logic               r_retry;

  logic [DATA_W-1:0]  r_cpu_rdata;
  logic               r_cpu_ready;
  logic               r_cpu_busy;
  logic [INDEX_W-1:0] r_set_index;
  logic               r_set_enable;
  logic [1:0]         r_set_word;
  logic               r_set_cmp;
  logic               r_set_write;
  logic [TAG_W-1:0]   r_set_tag;
  logic [DATA_W-1:0]  r_set_data_in;
  logic               r_set_valid_in;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;

  assign cpu_rdata    = r_cpu_rdata;
  assign cpu_ready    = r_cpu_ready;
  assign cpu_busy     = r_cpu_busy;
  assign set_index    = r_set_index;
  assign set_enable   = r_set_enable;
  assign set_word     = r_set_word;
  assign set_cmp      = r_set_cmp;
  assign set_write    = r_set_write;
  assign set_tag      = r_set_tag;
  assign set_data_in  = r_set_data_in;
  assign set_valid_in = r_set_valid_in;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;

  // Each set/memory state raises its strobe on entry (strobe is low then) and drops it on the
  // ack edge, so every access is separated from the next by at least one idle cycle.
  // NOTE: all state and outputs use non-blocking assignments so every register sees the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_we           <= 1'b0;
      r_tag          <= '0;
      r_word         <= '0;
      r_wdata        <= '0;
      r_victim_tag   <= '0;
      r_data         <= '0;
      r_retry        <= 1'b0;
      r_cpu_rdata    <= '0;
      r_cpu_ready    <= 1'b0;
      r_cpu_busy     <= 1'b0;
      r_set_index    <= '0;
      r_set_enable   <= 1'b0;
      r_set_word     <= '0;
      r_set_cmp      <= 1'b0;
      r_set_write    <= 1'b0;
      r_set_tag      <= '0;
      r_set_data_in  <= '0;
      r_set_valid_in <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_we        <= cpu_we;
            r_tag       <= w_req_tag;
            r_word      <= w_req_word;
            r_wdata     <= cpu_wdata;
            r_set_index <= w_req_index;
            r_cpu_busy  <= 1'b1;
            r_retry     <= 1'b0;
            r_state     <= S_COMPARE;
          end
        end

        S_COMPARE: begin
          if (!r_set_enable) begin
            r_set_enable   <= 1'b1;
            r_set_cmp      <= 1'b1;
            r_set_write    <= r_we;
            r_set_tag      <= r_tag;
            r_set_word     <= r_word;
            r_set_data_in  <= r_wdata;
            r_set_valid_in <= 1'b1;
          end else if (set_ack) begin
            r_set_enable <= 1'b0;
            if (set_hit && set_valid) begin
              if (!r_we) r_cpu_rdata <= set_data_out;
              r_cpu_ready <= 1'b1;
              r_cpu_busy  <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_victim_tag <= set_tag_out;
              r_cnt        <= '0;
              // A miss right after our own fill cannot have a legitimate dirty victim.
              r_state      <= (!r_retry && set_dirty && set_valid) ? S_WB_RD : S_FILL_MEM;
            end
          end
        end

        S_WB_RD: begin
          if (!r_set_enable) begin
            r_set_enable   <= 1'b1;
            r_set_cmp      <= 1'b0;
            r_set_write    <= 1'b0;
            r_set_valid_in <= 1'b0;
            r_set_tag      <= r_tag;
            r_set_word     <= r_cnt;
          end else if (set_ack) begin
            r_set_enable <= 1'b0;
            r_data       <= set_data_out;
            r_state      <= S_WB_MEM;
          end
        end

        S_WB_MEM: begin
          if (!r_mem_req) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {r_victim_tag, r_set_index, r_cnt};
            r_mem_wdata <= r_data;
          end else if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_cnt     <= (r_cnt == LAST_WORD) ? 2'd0 : r_cnt + 2'd1;
            r_state   <= (r_cnt == LAST_WORD) ? S_FILL_MEM : S_WB_RD;
          end
        end

        S_FILL_MEM: begin
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {r_tag, r_set_index, r_cnt};
          end else if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_data    <= mem_rdata;
            r_state   <= S_FILL_WR;
          end
        end

        S_FILL_WR: begin
          if (!r_set_enable) begin
            r_set_enable   <= 1'b1;
            r_set_cmp      <= 1'b0;
            r_set_write    <= 1'b1;
            r_set_valid_in <= 1'b1;
            r_set_tag      <= r_tag;
            r_set_word     <= r_cnt;
            r_set_data_in  <= r_data;
          end else if (set_ack) begin
            r_set_enable <= 1'b0;
            if (r_cnt == LAST_WORD) begin
              r_cnt   <= '0;
              r_retry <= 1'b1;
              r_state <= S_COMPARE;
            end else begin
              r_cnt   <= r_cnt + 2'd1;
              r_state <= S_FILL_MEM;
            end
          end
        end

        S_DONE: begin
          r_cpu_ready <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: behavioural set and memory models, a line-level
// write-back/write-allocate reference model, directed corner cases and randomized traffic.
module tb_cache_ctrl;

  localparam int TAG_W   = 5;
  localparam int INDEX_W = 3;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = TAG_W + INDEX_W + 2;
  localparam int LINES   = 1 << INDEX_W;
  localparam int MWORDS  = 1 << ADDR_W;

  typedef logic [ADDR_W+DATA_W:0] beat_t;  // {we, addr, data}

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_ready, cpu_busy;
  logic [INDEX_W-1:0] set_index;
  logic              set_enable, set_cmp, set_write, set_valid_in;
  logic [1:0]        set_word;
  logic [TAG_W-1:0]  set_tag, set_tag_out;
  logic [DATA_W-1:0] set_data_in, set_data_out;
  logic              set_hit, set_dirty, set_valid, set_ack;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  cache_ctrl #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
    .set_index(set_index), .set_enable(set_enable), .set_word(set_word), .set_cmp(set_cmp),
    .set_write(set_write), .set_tag(set_tag), .set_data_in(set_data_in),
    .set_valid_in(set_valid_in), .set_hit(set_hit), .set_dirty(set_dirty),
    .set_valid(set_valid), .set_ack(set_ack), .set_tag_out(set_tag_out),
    .set_data_out(set_data_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial forever #5 clk = ~clk;

  // Environment: backing memory and the cache set contents.
  logic [DATA_W-1:0] mem  [MWORDS];
  logic              sv   [LINES];
  logic              sd   [LINES];
  logic [TAG_W-1:0]  stag [LINES];
  logic [DATA_W-1:0] sdat [LINES][4];

  // Reference model: coherent memory image plus line-level tag/valid/dirty state.
  logic [DATA_W-1:0] gold [MWORDS];
  logic              tv   [LINES];
  logic              td   [LINES];
  logic [TAG_W-1:0]  tt   [LINES];

  int    set_lat_max, mem_lat_min, mem_lat_max;
  int    s_wait, m_wait;
  bit    s_active, m_active;
  beat_t exp_q[$];
  beat_t act_q[$];
  int    en_rises, proto_err;
  logic [1:0] last_cw;
  int    n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Set model: responds after 0..set_lat_max extra cycles, ack held for one cycle.
  always @(negedge clk) begin : set_model
    int ix;
    if (!rst_n) begin
      set_ack = 1'b0; s_active = 1'b0;
    end else if (set_ack) begin
      set_ack = 1'b0;
    end else if (set_enable) begin
      if (!s_active) begin s_active = 1'b1; s_wait = $urandom_range(0, set_lat_max); end
      if (s_wait > 0) s_wait--;
      else begin
        ix           = int'(set_index);
        set_valid    = sv[ix];
        set_dirty    = sd[ix];
        set_tag_out  = stag[ix];
        set_hit      = sv[ix] && (stag[ix] == set_tag);
        set_data_out = sdat[ix][set_word];
        if (set_cmp && set_write && set_hit) begin
          sdat[ix][set_word] = set_data_in;
          sd[ix] = 1'b1;
        end else if (!set_cmp && set_write) begin
          sdat[ix][set_word] = set_data_in;
          stag[ix] = set_tag;
          sv[ix]   = set_valid_in;
          sd[ix]   = 1'b0;
        end
        set_ack  = 1'b1;
        s_active = 1'b0;
      end
    end
  end

  // Memory model: latency drawn per beat, every completed beat logged.
  always @(negedge clk) begin : mem_model
    if (!rst_n) begin
      mem_ack = 1'b0; m_active = 1'b0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (!m_active) begin m_active = 1'b1; m_wait = $urandom_range(mem_lat_min, mem_lat_max); end
      if (m_wait > 0) m_wait--;
      else begin
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          act_q.push_back({1'b1, mem_addr, mem_wdata});
        end else begin
          mem_rdata = mem[mem_addr];
          act_q.push_back({1'b0, mem_addr, mem[mem_addr]});
        end
        mem_ack  = 1'b1;
        m_active = 1'b0;
      end
    end
  end

  // Protocol monitor, sampled just after each rising edge.
  logic        prev_en, prev_req;
  logic [28:0] ssnap;
  logic [26:0] msnap;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_en = 1'b0; prev_req = 1'b0;
    end else begin
      if (prev_en && set_ack && set_enable) proto_err++;
      if (prev_en && !set_ack && (!set_enable ||
          {set_cmp, set_write, set_word, set_tag, set_data_in, set_valid_in, set_index} != ssnap))
        proto_err++;
      if (!prev_en && set_enable) begin
        en_rises++;
        ssnap   = {set_cmp, set_write, set_word, set_tag, set_data_in, set_valid_in, set_index};
        last_cw = {set_cmp, set_write};
        if (!set_cmp && set_write && !set_valid_in) proto_err++;
      end
      if (prev_req && !mem_ack && (!mem_req || {mem_we, mem_addr, mem_wdata} != msnap))
        proto_err++;
      if (!prev_req && mem_req) msnap = {mem_we, mem_addr, mem_wdata};
      prev_en  = set_enable;
      prev_req = mem_req;
    end
  end

  task automatic preload(input int ix, input logic dirty, input logic [TAG_W-1:0] tag,
                         input logic [DATA_W-1:0] word2);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    sv[ix] = 1'b1; sd[ix] = dirty; stag[ix] = tag;
    tv[ix] = 1'b1; td[ix] = dirty; tt[ix] = tag;
    for (int w = 0; w < 4; w++) begin
      d = (w == 2) ? word2 : DATA_W'($urandom);
      a = {tag, INDEX_W'(ix), 2'(w)};
      sdat[ix][w] = d;
      gold[a]     = d;
      mem[a]      = dirty ? ~d : d;
    end
  endtask

  // One CPU transaction; expectations come from the reference model before it is issued.
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input bit hold);
    logic [TAG_W-1:0]  tag;
    int                ix, exp_en, cyc, extra;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] exp_rd;
    tag = addr[ADDR_W-1 -: TAG_W];
    ix  = int'(addr[2 +: INDEX_W]);
    exp_q.delete();
    if (tv[ix] && tt[ix] == tag) exp_en = 1;
    else begin
      exp_en = 6;
      if (td[ix]) begin
        exp_en = 10;
        for (int w = 0; w < 4; w++) begin
          a = {tt[ix], INDEX_W'(ix), 2'(w)};
          exp_q.push_back({1'b1, a, gold[a]});
        end
      end
      for (int w = 0; w < 4; w++) begin
        a = {tag, INDEX_W'(ix), 2'(w)};
        exp_q.push_back({1'b0, a, gold[a]});
      end
      tv[ix] = 1'b1; tt[ix] = tag; td[ix] = 1'b0;
    end
    if (we) begin gold[addr] = wdata; td[ix] = 1'b1; end
    exp_rd = gold[addr];

    @(negedge clk);
    act_q.delete(); en_rises = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    check("busy_on_capture", cpu_busy, 1);
    if (hold) begin
      cpu_we = ~we; cpu_addr = ~addr; cpu_wdata = ~wdata;
    end else cpu_req = 1'b0;
    cyc = 0;
    while (!cpu_ready && cyc < 3000) begin @(negedge clk); cyc++; end
    cpu_req = 1'b0;
    check("ready_seen", cpu_ready, 1);
    check("busy_at_ready", cpu_busy, 0);
    if (!we) check("rdata", cpu_rdata, exp_rd);
    extra = 0;
    repeat (4) begin @(negedge clk); if (cpu_ready) extra++; end
    check("ready_one_pulse", extra, 0);
    check("mem_beat_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("mem_beat%0d", i), act_q[i], exp_q[i]);
    check("set_accesses", en_rises, exp_en);
  endtask

  initial begin : stim
    int cyc, bad;
    logic [ADDR_W-1:0] a;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    set_hit = 0; set_dirty = 0; set_valid = 0; set_ack = 0; set_tag_out = '0; set_data_out = '0;
    mem_ack = 0; mem_rdata = '0;
    set_lat_max = 0; mem_lat_min = 0; mem_lat_max = 0; proto_err = 0; en_rises = 0;
    for (int i = 0; i < MWORDS; i++) begin mem[i] = DATA_W'($urandom); gold[i] = mem[i]; end
    for (int l = 0; l < LINES; l++) begin
      sv[l] = 0; sd[l] = 0; stag[l] = '0; tv[l] = 0; td[l] = 0; tt[l] = '0;
      for (int w = 0; w < 4; w++) sdat[l][w] = '0;
    end

    repeat (3) @(negedge clk);
    check("rst_busy", cpu_busy, 0);
    check("rst_ready", cpu_ready, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_set_enable", set_enable, 0);
    check("rst_set_ctrl", {set_cmp, set_write, set_valid_in, set_index}, 0);
    check("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read hit, set acks one cycle after enable.
    preload(1, 1'b0, 5'h0A, 16'h0F0F);
    do_req(1'b0, {5'h0A, 3'd1, 2'd2}, '0, 1'b0);

    // Clean read miss into an invalid line.
    for (int w = 0; w < 4; w++) begin
      a = {5'b11101, 3'd3, 2'(w)};
      mem[a] = 16'hA000 + DATA_W'(w); gold[a] = mem[a];
    end
    set_lat_max = 1; mem_lat_max = 2;
    do_req(1'b0, {5'b11101, 3'd3, 2'd2}, '0, 1'b0);

    // Dirty write miss: victim written back, line filled, then compare-write.
    preload(5, 1'b1, 5'b00011, DATA_W'($urandom));
    do_req(1'b1, {5'b10101, 3'd5, 2'd1}, 16'hBEEF, 1'b0);
    check("final_cmp_write", last_cw, 2'b11);

    // Requests held high while busy must be ignored; re-issued ones accepted.
    do_req(1'b0, {5'h0A, 3'd1, 2'd2}, '0, 1'b1);
    do_req(1'b1, {5'h0A, 3'd1, 2'd0}, 16'h1234, 1'b1);
    do_req(1'b0, {5'h0A, 3'd1, 2'd0}, '0, 1'b0);

    // Memory stall of 10 cycles per beat.
    mem_lat_min = 10; mem_lat_max = 10;
    do_req(1'b0, {5'h07, 3'd6, 2'd3}, '0, 1'b0);

    mem_lat_min = 0; mem_lat_max = 3; set_lat_max = 2;
    for (int n = 0; n < 120; n++)
      do_req(1'(($urandom_range(0, 1))),
             {5'h10 + 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))},
             DATA_W'($urandom), 1'($urandom_range(0, 1)));

    // Asynchronous reset while a write-back beat is outstanding.
    do_req(1'b1, {5'h18, 3'd0, 2'd1}, DATA_W'($urandom), 1'b0);
    mem_lat_min = 3; mem_lat_max = 3;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {5'h19, 3'd0, 2'd0};
    @(negedge clk);
    cpu_req = 1'b0;
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 500) begin @(negedge clk); cyc++; end
    check("reached_wb_mem", mem_req & mem_we, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", mem_req, 0);
    check("async_rst_set_enable", set_enable, 0);
    check("async_rst_busy", cpu_busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    act_q.delete(); en_rises = 0;
    repeat (20) @(negedge clk);
    check("post_rst_mem_beats", act_q.size(), 0);
    check("post_rst_set_accesses", en_rises, 0);
    check("post_rst_busy", cpu_busy, 0);
    mem_lat_min = 0; mem_lat_max = 2;
    do_req(1'b0, {5'h19, 3'd0, 2'd0}, '0, 1'b0);

    repeat (5) @(negedge clk);
    check("protocol_violations", proto_err, 0);
    bad = 0;
    for (int i = 0; i < MWORDS; i++) begin
      a = ADDR_W'(i);
      if (sv[a[4:2]] && stag[a[4:2]] == a[9:5]) begin
        if (sdat[a[4:2]][a[1:0]] !== gold[i]) bad++;
        if (!sd[a[4:2]] && mem[i] !== gold[i]) bad++;
      end else if (mem[i] !== gold[i]) bad++;
    end
    check("coherent_image", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Cache controller FSM sitting directly upstream of the cache `set` block.
- Accepts CPU word read/write requests, drives the set's enable/cmp/write/word/tag/data_in/valid_in inputs, and consumes its hit/dirty/tag_out/data_out/valid/ack outputs.
- On a miss it writes back a dirty victim line to memory, fills the line from memory word by word, then retries the access.
- Policy: write-back, write-allocate, one outstanding request.

Parameters:
- TAG_W, 5, tag width; matches the set's tag port.
- INDEX_W, 3, set index width; driven to the set-array decoder.
- DATA_W, 16, word width.
- WORDS, 4, words per line; word counter is 2 bits, fixed.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  request strobe, sampled only in IDLE
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  TAG_W+INDEX_W+2  {tag, index, word}
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid with cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- cpu_busy  out  1  high from request capture until cpu_ready
- set_index  out  INDEX_W  selected set
- set_enable  out  1  set access strobe
- set_word  out  2  word select
- set_cmp  out  1  compare mode
- set_write  out  1  write mode
- set_tag  out  TAG_W  tag to set
- set_data_in  out  DATA_W  data to set
- set_valid_in  out  1  valid bit written on fill
- set_hit, set_dirty, set_valid, set_ack  in  1 each  set status
- set_tag_out  in  TAG_W  stored tag
- set_data_out  in  DATA_W  stored word
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  TAG_W+INDEX_W+2  word address
- mem_wdata  out  DATA_W  write-back data
- mem_rdata  in  DATA_W  fill data, valid with mem_ack
- mem_ack  in  1  one-cycle memory completion

Behaviour:
- Reset: all outputs 0, state IDLE, word counter 0, request registers cleared. Async reset mid-operation aborts immediately: mem_req and set_enable drop asynchronously; no retry after release.
- Set access rule: set_enable is held high with all set_* inputs stable until set_ack is sampled 1. set_enable is low for the following cycle. Every access therefore has at least one idle cycle between enables.
- IDLE: cpu_req=1 latches addr/we/wdata, sets cpu_busy, goes to COMPARE. Requests while busy are ignored.
- COMPARE: set_cmp=1, set_write=cpu_we, set_tag/word from the latched address, set_data_in=wdata.
  - On ack with set_hit & set_valid: go to DONE; capture set_data_out for a read.
  - On ack with a miss: latch set_tag_out and set_dirty as the victim. Dirty & valid goes to WB_RD with counter=0; otherwise goes to FILL_MEM with counter=0.
- WB_RD: cmp=0, write=0, word=counter; on ack, capture set_data_out and go to WB_MEM.
- WB_MEM: mem_req=1, mem_we=1, mem_addr={victim_tag, index, counter}, mem_wdata=captured word; hold until mem_ack. On mem_ack, counter=3 goes to FILL_MEM with counter=0; otherwise counter+1 and back to WB_RD.
- FILL_MEM: mem_req=1, mem_we=0, mem_addr={req_tag, index, counter}; on mem_ack, capture mem_rdata and go to FILL_WR.
- FILL_WR: cmp=0, write=1, valid_in=1, tag=req_tag, data_in=captured word. The set clears dirty on this write. On ack, counter=3 goes to COMPARE (retry, must hit); otherwise counter+1 and back to FILL_MEM.
- DONE: cpu_ready=1 for one cycle, cpu_rdata=captured word (read) or unchanged (write), cpu_busy drops, state returns to IDLE.
- Miss on retry COMPARE is a protocol error: the FSM re-enters the fill path rather than hanging.
- Counter wraps 3→0 only at phase transitions. Word order is always 0..3, not critical-word-first.

Test Plan:
- Reset: rst_n low mid-WB_MEM -> mem_req=0, set_enable=0, cpu_busy=0 immediately; after release IDLE, no memory traffic.
- Read hit (set model acks 1 cycle after enable, hit=1, data_out=16'h0F0F) -> cpu_ready pulse with cpu_rdata=16'h0F0F; exactly one set enable, no mem_req.
- Clean read miss, addr tag=5'b11101, index=3, word=2, memory returns 16'hA000+word -> 4 mem reads at word addresses 0..3, 4 fill writes with valid_in=1, retry hit, cpu_rdata=16'hA002.
- Dirty write miss, victim tag=5'b00011 -> 4 mem writes to {5'b00011, index, 0..3} with the set's stored words, then 4 fills, then compare-write with cmp=1 write=1; cpu_ready once.
- Back-to-back: second cpu_req asserted while busy -> ignored; re-asserted after cpu_ready -> accepted; set_enable low ≥1 cycle between all accesses.
- Memory stall: mem_ack delayed 10 cycles -> mem_req and mem_addr stable throughout, no extra beats.
